// File: rtl/ipsxe_floating_point_normround_v2_0.sv
// Normalise-and-round back end for a floating-point datapath.
// Three-stage pipeline: leading-zero count, normalising shift, IEEE rounding and packing.
module ipsxe_floating_point_normround_v2_0 #(
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned MAN_WIDTH = 23,
    parameter int unsigned LZC_WIDTH = 6,
    parameter int unsigned W_USER    = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_aclken,
    input  logic                           i_valid,
    input  logic                           i_sign,
    input  logic [EXP_WIDTH:0]             i_exp,
    input  logic [2*MAN_WIDTH+2:0]         i_man,
    input  logic [1:0]                     i_rnd_mode,
    input  logic                           i_nan,
    input  logic                           i_inf,
    input  logic [W_USER-1:0]              i_user,
    output logic                           o_valid,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   o_result,
    output logic                           o_overflow,
    output logic                           o_underflow,
    output logic                           o_inexact,
    output logic [W_USER-1:0]              o_user
);

    localparam int unsigned MW_IN = 2 * (MAN_WIDTH + 1) + 1;
    localparam int unsigned EW3   = EXP_WIDTH + 3;
    localparam int unsigned RW    = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int unsigned GI    = MW_IN - 1 - MAN_WIDTH;
    localparam int unsigned EMAX  = (2 ** EXP_WIDTH) - 2;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [EXP_WIDTH-1:0] EXP_MAXF = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [MAN_WIDTH-1:0] MAN_ZERO = '0;
    localparam logic [MAN_WIDTH-1:0] MAN_ONES = '1;
    localparam logic [MAN_WIDTH-1:0] QNAN_MAN = {1'b1, {(MAN_WIDTH-1){1'b0}}};

    // ---------------- stage 1: capture inputs and leading-zero count ----------------
    logic [LZC_WIDTH-1:0]  lz_d;

    logic                  s1_valid_q;
    logic                  s1_sign_q;
    logic [EXP_WIDTH:0]    s1_exp_q;
    logic [MW_IN-1:0]      s1_man_q;
    logic [1:0]            s1_rnd_q;
    logic                  s1_nan_q;
    logic                  s1_inf_q;
    logic [W_USER-1:0]     s1_user_q;
    logic [LZC_WIDTH-1:0]  s1_lz_q;

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        lz_d = LZC_WIDTH'(MW_IN);
        for (int unsigned i = 0; i < MW_IN; i++) begin
            if (i_man[i]) begin
                lz_d = LZC_WIDTH'(MW_IN - 1 - i);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s1_rnd_q   <= '0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_user_q  <= '0;
            s1_lz_q    <= '0;
        end else if (i_aclken) begin
            s1_valid_q <= i_valid;
            s1_sign_q  <= i_sign;
            s1_exp_q   <= i_exp;
            s1_man_q   <= i_man;
            s1_rnd_q   <= i_rnd_mode;
            s1_nan_q   <= i_nan;
            s1_inf_q   <= i_inf;
            s1_user_q  <= i_user;
            s1_lz_q    <= lz_d;
        end
    end

    // ---------------- stage 2: normalising shift and exponent adjust ----------------
    logic [MW_IN-1:0]      s2_sh_d;
    logic [EW3-1:0]        s2_e_d;
    logic                  s2_zero_d;

    logic                  s2_valid_q;
    logic                  s2_sign_q;
    logic [MW_IN-1:0]      s2_sh_q;
    logic [EW3-1:0]        s2_e_q;
    logic [1:0]            s2_rnd_q;
    logic                  s2_nan_q;
    logic                  s2_inf_q;
    logic                  s2_zero_q;
    logic [W_USER-1:0]     s2_user_q;

    // The extra shift by one pushes the hidden bit out of the top of the field.
    always_comb begin
        s2_sh_d   = (s1_man_q << s1_lz_q) << 1;
        s2_e_d    = EW3'(s1_exp_q) + EW3'(2) - EW3'(s1_lz_q);
        s2_zero_d = (s1_man_q == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_sh_q    <= '0;
            s2_e_q     <= '0;
            s2_rnd_q   <= '0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_user_q  <= '0;
        end else if (i_aclken) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_sh_q    <= s2_sh_d;
            s2_e_q     <= s2_e_d;
            s2_rnd_q   <= s1_rnd_q;
            s2_nan_q   <= s1_nan_q;
            s2_inf_q   <= s1_inf_q;
            s2_zero_q  <= s2_zero_d;
            s2_user_q  <= s1_user_q;
        end
    end

    // ---------------- stage 3: round, detect range exceptions, pack ----------------
    logic [MAN_WIDTH-1:0]  frac;
    logic                  guard;
    logic                  sticky;
    logic                  inc;
    logic [MAN_WIDTH:0]    frac_sum;
    logic                  carry;
    logic [MAN_WIDTH-1:0]  frac_r;
    logic [EW3-1:0]        e_r;
    logic                  ovf;
    logic                  unf;
    logic                  sel_inf;

    logic [RW-1:0]         res_d;
    logic                  ovf_d;
    logic                  unf_d;
    logic                  inex_d;

    assign frac   = s2_sh_q[MW_IN-1 -: MAN_WIDTH];
    assign guard  = s2_sh_q[GI];
    assign sticky = |s2_sh_q[GI-1:0];

    always_comb begin
        inc = 1'b0;
        case (s2_rnd_q)
            RM_RNE:  inc = guard & (sticky | frac[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = (guard | sticky) & ~s2_sign_q;
            default: inc = (guard | sticky) & s2_sign_q;
        endcase

        frac_sum = {1'b0, frac} + (MAN_WIDTH+1)'(inc);
        carry    = frac_sum[MAN_WIDTH];
        frac_r   = carry ? MAN_ZERO : frac_sum[MAN_WIDTH-1:0];
        e_r      = s2_e_q + EW3'(carry);
        ovf      = $signed(e_r) > $signed(EW3'(EMAX));
        unf      = $signed(e_r) < $signed(EW3'(1));

        // Overflow saturates to infinity only when rounding points away from zero.
        sel_inf  = (s2_rnd_q == RM_RNE) ||
                   ((s2_rnd_q == RM_RUP) && !s2_sign_q) ||
                   ((s2_rnd_q != RM_RUP) && (s2_rnd_q != RM_RTZ) && s2_sign_q);
    end

    always_comb begin
        res_d  = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        inex_d = 1'b0;
        if (s2_nan_q) begin
            res_d = {1'b0, EXP_ONES, QNAN_MAN};
        end else if (s2_inf_q) begin
            res_d = {s2_sign_q, EXP_ONES, MAN_ZERO};
        end else if (s2_zero_q) begin
            res_d = {s2_sign_q, (RW-1)'(0)};
        end else if (ovf) begin
            ovf_d  = 1'b1;
            inex_d = 1'b1;
            res_d  = sel_inf ? {s2_sign_q, EXP_ONES, MAN_ZERO}
                             : {s2_sign_q, EXP_MAXF, MAN_ONES};
        end else if (unf) begin
            unf_d  = 1'b1;
            inex_d = 1'b1;
            res_d  = {s2_sign_q, (RW-1)'(0)};
        end else begin
            inex_d = guard | sticky;
            res_d  = {s2_sign_q, e_r[EXP_WIDTH-1:0], frac_r};
        end
    end

    logic                  valid_q;
    logic [RW-1:0]         result_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  inex_q;
    logic [W_USER-1:0]     user_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inex_q   <= 1'b0;
            user_q   <= '0;
        end else if (i_aclken) begin
            valid_q  <= s2_valid_q;
            result_q <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inex_q   <= inex_d;
            user_q   <= s2_user_q;
        end
    end

    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_inexact   = inex_q;
    assign o_user      = user_q;

endmodule

// File: tb/tb_ipsxe_floating_point_normround_v2_0.sv
// Bench for the normalise/round pipeline: directed corner cases, stall and reset
// sequences, and random traffic scored against an arithmetic reference model.
module tb_ipsxe_floating_point_normround_v2_0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inex;
        logic        user;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        aclken;
    logic        valid;
    logic        sign;
    logic [8:0]  exp_in;
    logic [48:0] man;
    logic [1:0]  mode;
    logic        nan;
    logic        inf;
    logic [0:0]  user;

    logic        o_valid;
    logic [31:0] o_result;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_inexact;
    logic [0:0]  o_user;

    logic        dir_use;
    exp_t        dir_exp;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ipsxe_floating_point_normround_v2_0 dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_aclken    (aclken),
        .i_valid     (valid),
        .i_sign      (sign),
        .i_exp       (exp_in),
        .i_man       (man),
        .i_rnd_mode  (mode),
        .i_nan       (nan),
        .i_inf       (inf),
        .i_user      (user),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_inexact   (o_inexact),
        .o_user      (o_user)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Value-level model: exact significand, round by comparing the discarded part with a half ulp.
    function automatic exp_t model(input logic s, input logic [8:0] e_in, input logic [48:0] m_in,
                                   input logic [1:0] rm, input logic fnan, input logic finf,
                                   input logic u);
        exp_t r;
        longint unsigned m, rem, frac, lo, half;
        int p, e;
        bit up;
        r = '0;
        r.user = u;
        if (fnan)            r.res = 32'h7FC00000;
        else if (finf)       r.res = {s, 8'hFF, 23'h0};
        else if (m_in == 0)  r.res = {s, 31'h0};
        else begin
            m = 64'(m_in);
            p = 0;
            for (int i = 0; i < 49; i++) if (m[i]) p = i;
            e = int'(e_in) - 46 + p;
            rem = m - (64'd1 << p);
            if (p > 23) begin
                lo   = rem & ((64'd1 << (p - 23)) - 64'd1);
                frac = rem >> (p - 23);
                half = 64'd1 << (p - 24);
            end else begin
                frac = rem << (23 - p);
                lo   = 0;
                half = 1;
            end
            r.inex = (lo != 0);
            case (rm)
                2'd0:    up = (lo > half) || ((lo == half) && frac[0]);
                2'd1:    up = 1'b0;
                2'd2:    up = r.inex && !s;
                default: up = r.inex && s;
            endcase
            if (up) frac++;
            if (frac == (64'd1 << 23)) begin
                frac = 0;
                e++;
            end
            if (e > 254) begin
                r.ovf  = 1'b1;
                r.inex = 1'b1;
                if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s))
                    r.res = {s, 8'hFF, 23'h0};
                else
                    r.res = {s, 8'hFE, 23'h7FFFFF};
            end else if (e < 1) begin
                r.unf  = 1'b1;
                r.inex = 1'b1;
                r.res  = {s, 31'h0};
            end else begin
                r.res = {s, 8'(e), 23'(frac)};
            end
        end
        return r;
    endfunction

    // Acceptance scoreboard: one expected entry per enabled edge with valid input.
    logic en_last = 1'b0;
    always @(posedge clk) begin
        exp_t t;
        en_last = aclken && !rst;
        if (rst) begin
            q.delete();
        end else if (aclken && valid) begin
            if (dir_use) begin
                t = dir_exp;
                t.user = user[0];
            end else begin
                t = model(sign, exp_in, man, mode, nan, inf, user[0]);
            end
            q.push_back(t);
        end
    end

    exp_t prev_obs = '0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin : mon
        exp_t cur, w;
        cur = {o_result, o_overflow, o_underflow, o_inexact, o_user[0]};
        if (rst) begin
            chk("rst_out", 64'({o_valid, cur}), 64'd0);
        end else if (!en_last) begin
            chk("hold", 64'({o_valid, cur}), 64'({prev_valid, prev_obs}));
        end else if (o_valid) begin
            if (q.size() == 0) begin
                chk("unexp_valid", 64'(o_valid), 64'd0);
            end else begin
                w = q.pop_front();
                chk("res", 64'(o_result), 64'(w.res));
                chk("flags", 64'({o_overflow, o_underflow, o_inexact}), 64'({w.ovf, w.unf, w.inex}));
                chk("user", 64'(o_user), 64'(w.user));
            end
        end
        prev_obs   = cur;
        prev_valid = o_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid   = 1'b0;
        dir_use = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic dsend(input logic s, input logic [8:0] e, input logic [48:0] m, input logic [1:0] rm,
                         input logic fnan, input logic finf, input logic [31:0] res,
                         input logic fo, input logic fu, input logic fi);
        valid   = 1'b1;
        sign    = s;
        exp_in  = e;
        man     = m;
        mode    = rm;
        nan     = fnan;
        inf     = finf;
        user    = 1'($urandom);
        dir_use = 1'b1;
        dir_exp = '{res: res, ovf: fo, unf: fu, inex: fi, user: 1'b0};
        step();
    endtask

    task automatic rand_inputs();
        longint unsigned tmp;
        int k;
        valid   = 1'b1;
        dir_use = 1'b0;
        sign    = 1'($urandom);
        mode    = 2'($urandom);
        user    = 1'($urandom);
        nan     = ($urandom_range(0, 15) == 0);
        inf     = ($urandom_range(0, 15) == 0);
        exp_in  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(90, 170));
        case ($urandom_range(0, 7))
            0: man = '0;
            1, 2: man = (49'd1 << 48) | (49'($urandom_range(0, (1 << 23) - 1)) << 25) | (49'd1 << 24);
            default: begin
                k   = $urandom_range(1, 49);
                tmp = {$urandom, $urandom};
                man = 49'(tmp & ((64'd1 << k) - 64'd1)) | (49'd1 << (k - 1));
            end
        endcase
    endtask

    initial begin
        rst = 1'b1; aclken = 1'b1; valid = 1'b0; sign = 1'b0; exp_in = '0; man = '0;
        mode = '0; nan = 1'b0; inf = 1'b0; user = '0; dir_use = 1'b0; dir_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Directed corner cases with hand-derived results.
        dsend(0, 127, 49'd1 << 46, 0, 0, 0, 32'h3F800000, 0, 0, 0);
        dsend(0, 127, 49'd1 << 48, 0, 0, 0, 32'h40800000, 0, 0, 0);
        dsend(0, 127, (49'd1 << 46) | (49'd1 << 22), 0, 0, 0, 32'h3F800000, 0, 0, 1);
        dsend(0, 127, (49'd1 << 46) | (49'd1 << 22), 2, 0, 0, 32'h3F800001, 0, 0, 1);
        dsend(0, 127, (49'd1 << 46) | (49'd1 << 23) | (49'd1 << 22), 0, 0, 0, 32'h3F800002, 0, 0, 1);
        dsend(0, 255, 49'd1 << 46, 0, 0, 0, 32'h7F800000, 1, 0, 1);
        dsend(0, 255, 49'd1 << 46, 1, 0, 0, 32'h7F7FFFFF, 1, 0, 1);
        dsend(1, 255, 49'd1 << 46, 2, 0, 0, 32'hFF7FFFFF, 1, 0, 1);
        dsend(1, 255, 49'd1 << 46, 3, 0, 0, 32'hFF800000, 1, 0, 1);
        dsend(0, 255, 49'd1 << 46, 3, 0, 0, 32'h7F7FFFFF, 1, 0, 1);
        dsend(1, 0,   49'd1 << 46, 0, 0, 0, 32'h80000000, 0, 1, 1);
        dsend(0, 127, 49'd0,       0, 0, 0, 32'h00000000, 0, 0, 0);
        dsend(0, 127, 49'd1 << 46, 0, 1, 0, 32'h7FC00000, 0, 0, 0);
        dsend(1, 127, 49'd1 << 46, 0, 0, 1, 32'hFF800000, 0, 0, 0);
        idle(5);

        // Six back-to-back samples with a two-cycle enable drop in the middle.
        for (int i = 0; i < 6; i++) begin
            rand_inputs();
            if (i == 3) begin
                aclken = 1'b0;
                step();
                step();
                aclken = 1'b1;
            end
            step();
        end
        idle(5);

        // Reset with samples in flight: none of them may emerge.
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
        end
        rst = 1'b1;
        valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        idle(6);
        dsend(0, 127, 49'd1 << 46, 0, 0, 0, 32'h3F800000, 0, 0, 0);
        idle(5);

        // Random traffic with random enable and valid gaps.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            valid  = ($urandom_range(0, 4) != 0);
            aclken = ($urandom_range(0, 5) != 0);
            step();
        end

        valid   = 1'b0;
        dir_use = 1'b0;
        aclken  = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        step();
        chk("drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
